// File: rtl/regfile_scoreboard.sv
// Parametrised register file with per-register pending bits, optional bypass and
// zero register, and a sequential bulk-clear engine that sweeps one entry per cycle.
module regfile_scoreboard #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        write_reg,
    input  logic signed [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0]        read_reg1,
    input  logic [ADDR_W-1:0]        read_reg2,
    output logic signed [DATA_W-1:0] read_data1,
    output logic signed [DATA_W-1:0] read_data2,
    input  logic                     mark_valid,
    input  logic [ADDR_W-1:0]        mark_reg,
    output logic                     pend1,
    output logic                     pend2,
    input  logic                     clear_req,
    output logic                     busy
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [DATA_W-1:0]  r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]       r_pend;
    logic [ADDR_W-1:0]         r_idx;

    logic w_idle;
    logic w_wr_en;
    logic w_mark_en;
    logic w_byp_en;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_wr_en   = w_idle && RegWrite && !((ZERO_REG != 0) && (write_reg == '0));
    assign w_mark_en = w_idle && mark_valid && !((ZERO_REG != 0) && (mark_reg == '0));
    assign w_byp_en  = (BYPASS != 0) && w_idle && RegWrite;
    assign busy      = (r_state == ST_CLEAR);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (clear_req) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_idx == ADDR_W'(NUM_REGS - 1)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Mark is applied after write so a same-edge write+mark leaves the entry pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_pend  <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                if (w_wr_en) begin
                    r_regs[write_reg] <= write_data;
                    r_pend[write_reg] <= 1'b0;
                end
                if (w_mark_en) r_pend[mark_reg] <= 1'b1;
                if (clear_req) r_idx <= '0;
            end else begin
                r_regs[r_idx] <= '0;
                r_pend[r_idx] <= 1'b0;
                r_idx         <= r_idx + 1'b1;
            end
        end
    end

    function automatic logic signed [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
        if ((ZERO_REG != 0) && (a == '0)) return '0;
        if (w_byp_en && (write_reg == a)) return write_data;
        return r_regs[a];
    endfunction

    // A forwarded write already supplies the value, so its pending bit is masked.
    function automatic logic rd_pend(input logic [ADDR_W-1:0] a);
        if ((ZERO_REG != 0) && (a == '0)) return 1'b0;
        if (w_byp_en && (write_reg == a)) return 1'b0;
        return r_pend[a];
    endfunction

    always_comb begin
        read_data1 = rd_data(read_reg1);
        read_data2 = rd_data(read_reg2);
        pend1      = rd_pend(read_reg1);
        pend2      = rd_pend(read_reg2);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: three instances (bypass, no bypass,
// zero register) share one stimulus stream; expected values are hand-computed.
module tb_regfile_scoreboard;

    logic       clk;
    logic       reset;
    logic       RegWrite;
    logic [2:0] write_reg;
    logic [7:0] write_data;
    logic [2:0] read_reg1;
    logic [2:0] read_reg2;
    logic       mark_valid;
    logic [2:0] mark_reg;
    logic       clear_req;

    logic signed [7:0] rd1_b, rd2_b, rd1_n, rd2_n, rd1_z, rd2_z;
    logic p1_b, p2_b, p1_n, p2_n, p1_z, p2_z;
    logic busy_b, busy_n, busy_z;

    int n_cmp;
    int n_err;
    int n_busy;

    regfile_scoreboard #(.DATA_W(8), .NUM_REGS(8), .BYPASS(1), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_b), .read_data2(rd2_b), .mark_valid(mark_valid),
        .mark_reg(mark_reg), .pend1(p1_b), .pend2(p2_b), .clear_req(clear_req),
        .busy(busy_b)
    );

    regfile_scoreboard #(.DATA_W(8), .NUM_REGS(8), .BYPASS(0), .ZERO_REG(0)) dut_n (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_n), .read_data2(rd2_n), .mark_valid(mark_valid),
        .mark_reg(mark_reg), .pend1(p1_n), .pend2(p2_n), .clear_req(clear_req),
        .busy(busy_n)
    );

    regfile_scoreboard #(.DATA_W(8), .NUM_REGS(8), .BYPASS(1), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_z), .read_data2(rd2_z), .mark_valid(mark_valid),
        .mark_reg(mark_reg), .pend1(p1_z), .pend2(p2_z), .clear_req(clear_req),
        .busy(busy_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; checks then happen mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RegWrite   = 1'b0;
        mark_valid = 1'b0;
        clear_req  = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle_inputs();
        write_reg = '0; write_data = '0; mark_reg = '0;
        read_reg1 = 3'd3; read_reg2 = 3'd5;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_rd1", rd1_b, 8'h00);
        chk("rst_rd2", rd2_b, 8'h00);
        chk("rst_pend1", {7'b0, p1_b}, 8'h00);
        chk("rst_busy", {7'b0, busy_b}, 8'h00);

        // Write reg 3 = -5
        RegWrite = 1'b1; write_reg = 3'd3; write_data = 8'hFB; #1;
        chk("wr3_byp_same", rd1_b, 8'hFB);
        chk("wr3_nobyp_same", rd1_n, 8'h00);
        step(); RegWrite = 1'b0; #1;
        chk("wr3_next_b", rd1_b, 8'hFB);
        chk("wr3_next_n", rd1_n, 8'hFB);

        // Bypass on port 2
        RegWrite = 1'b1; write_reg = 3'd5; write_data = 8'h7F; #1;
        chk("byp5_b", rd2_b, 8'h7F);
        chk("byp5_n_old", rd2_n, 8'h00);
        step(); RegWrite = 1'b0; #1;
        chk("byp5_n_next", rd2_n, 8'h7F);

        // Scoreboard mark and clear-by-write
        read_reg1 = 3'd2; mark_valid = 1'b1; mark_reg = 3'd2; #1;
        chk("mark2_same", {7'b0, p1_b}, 8'h00);
        step(); mark_valid = 1'b0; #1;
        chk("mark2_b", {7'b0, p1_b}, 8'h01);
        chk("mark2_n", {7'b0, p1_n}, 8'h01);
        RegWrite = 1'b1; write_reg = 3'd2; write_data = 8'h10; #1;
        chk("wr2_pend_b_same", {7'b0, p1_b}, 8'h00);
        chk("wr2_pend_n_same", {7'b0, p1_n}, 8'h01);
        step(); RegWrite = 1'b0; #1;
        chk("wr2_pend_n_next", {7'b0, p1_n}, 8'h00);
        chk("wr2_data", rd1_b, 8'h10);

        // Same-edge write and mark of reg 4: mark wins
        read_reg2 = 3'd4;
        RegWrite = 1'b1; write_reg = 3'd4; write_data = 8'h44;
        mark_valid = 1'b1; mark_reg = 3'd4;
        step(); idle_inputs(); #1;
        chk("wm4_pend", {7'b0, p2_b}, 8'h01);
        chk("wm4_data", rd2_b, 8'h44);

        // Zero register
        read_reg1 = 3'd0;
        RegWrite = 1'b1; write_reg = 3'd0; write_data = 8'hAA;
        mark_valid = 1'b1; mark_reg = 3'd0; #1;
        chk("z0_byp_rd", rd1_z, 8'h00);
        chk("z0_byp_pend", {7'b0, p1_z}, 8'h00);
        chk("nz0_byp_rd", rd1_b, 8'hAA);
        step(); idle_inputs(); #1;
        chk("z0_rd", rd1_z, 8'h00);
        chk("z0_pend", {7'b0, p1_z}, 8'h00);
        chk("nz0_rd", rd1_b, 8'hAA);
        chk("nz0_pend", {7'b0, p1_b}, 8'h01);

        // Fill all registers and mark all pending
        for (int i = 0; i < 8; i++) begin
            RegWrite = 1'b1; write_reg = 3'(i); write_data = 8'(8'h11 * (i + 1));
            mark_valid = 1'b1; mark_reg = 3'(i);
            step();
        end
        idle_inputs();
        read_reg1 = 3'd7; read_reg2 = 3'd2; #1;
        chk("fill7_rd", rd1_b, 8'h88);
        chk("fill7_pend", {7'b0, p1_b}, 8'h01);

        // Bulk clear, with writes and marks attempted throughout
        clear_req = 1'b1; #1;
        chk("clr_busy_pre", {7'b0, busy_b}, 8'h00);
        step(); #1;
        chk("clr_busy_rise", {7'b0, busy_b}, 8'h01);
        RegWrite = 1'b1; write_reg = 3'd2; write_data = 8'h55;
        mark_valid = 1'b1; mark_reg = 3'd3; #1;
        chk("clr_no_byp", rd2_b, 8'h33);
        n_busy = 0;
        while (busy_b && n_busy < 20) begin
            n_busy++;
            step();
        end
        idle_inputs(); #1;
        chk("clr_busy_len", 8'(n_busy), 8'd8);
        for (int i = 0; i < 8; i++) begin
            read_reg1 = 3'(i); read_reg2 = 3'(7 - i); #1;
            chk($sformatf("clr_rd1_%0d", i), rd1_b, 8'h00);
            chk($sformatf("clr_pend2_%0d", 7 - i), {7'b0, p2_b}, 8'h00);
        end

        // Reset in the 3rd busy cycle
        RegWrite = 1'b1; write_reg = 3'd7; write_data = 8'h27; step();
        write_reg = 3'd1; write_data = 8'h21; step();
        idle_inputs(); read_reg1 = 3'd7; read_reg2 = 3'd1; #1;
        chk("pre_clr_rd7", rd1_b, 8'h27);
        clear_req = 1'b1; step(); clear_req = 1'b0;
        step(); step(); #1;
        chk("busy_cycle3", {7'b0, busy_b}, 8'h01);
        reset = 1'b1; step(); reset = 1'b0; #1;
        chk("rst_mid_busy", {7'b0, busy_b}, 8'h00);
        chk("rst_mid_rd7", rd1_b, 8'h00);
        chk("rst_mid_rd1", rd2_b, 8'h00);
        RegWrite = 1'b1; write_reg = 3'd7; write_data = 8'h5A; step();
        idle_inputs(); #1;
        chk("post_rst_wr7", rd1_b, 8'h5A);
        chk("post_rst_wr7_n", rd1_n, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
